// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with byte-enable writes,
// optional output register, and a clear engine that fills the array.
//
// Ports:
//   clk      - clock, all state changes on rising edge
//   rst      - asynchronous active-high reset
//   en       - access strobe, ignored while busy
//   wr       - 1 = write, 0 = read (qualified by en)
//   be       - byte enables for writes
//   addr     - word address
//   din      - write data
//   clr_req  - single-cycle request to re-clear the array
//   dout     - read data, holds between reads
//   dout_vld - one-cycle pulse with new dout
//   busy     - clear engine running, accesses ignored
module ram_sp_clr #(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       ADDR_W  = 3,
  parameter bit                OUT_REG = 1'b0,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic                clr_req,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_vld,
  output logic                busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              w_acc;
  logic              w_wr;
  logic              w_rd;
  logic              w_last;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_vld;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // DEPTH is a power of two, so the last address is all ones
  assign w_last = &r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc       = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_CLEAR: begin
        busy      = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      S_IDLE: begin
        // clear request wins over a same-cycle access
        if (clr_req) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end else begin
          w_acc = en;
        end
      end
    endcase
  end

  assign w_wr = w_acc & wr;
  assign w_rd = w_acc & ~wr;

  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= CLR_VAL;
    end else if (w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          r_mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  assign w_rdata = r_mem[addr];

  generate
    if (OUT_REG) begin : g_oreg
      logic [DATA_W-1:0] r_p_data;
      logic              r_p_vld;

      // second stage runs regardless of busy so an
      // in-flight read completes across a clear request
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_p_data   <= '0;
          r_p_vld    <= 1'b0;
          r_dout     <= '0;
          r_dout_vld <= 1'b0;
        end else begin
          r_p_vld    <= w_rd;
          r_dout_vld <= r_p_vld;
          if (w_rd) begin
            r_p_data <= w_rdata;
          end
          if (r_p_vld) begin
            r_dout <= r_p_data;
          end
        end
      end
    end else begin : g_direct
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_dout     <= '0;
          r_dout_vld <= 1'b0;
        end else begin
          r_dout_vld <= w_rd;
          if (w_rd) begin
            r_dout <= w_rdata;
          end
        end
      end
    end
  endgenerate

  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;

endmodule
